// File: rtl/inference_sequencer_if.sv
// inference_sequencer_if: control, memory-read and result signals of the inference sequencer; SEQ_SCORE_DEBUG_EN adds the per-class score tap
`timescale 1ns/1ps
interface inference_sequencer_if;
    logic        start;
    logic        weights_loaded;
    logic [12:0] weight_rd_addr;
    logic [7:0]  weight_rd_data;
    logic [3:0]  bias_rd_addr;
    logic [31:0] bias_rd_data;
    logic [9:0]  img_rd_addr;
    logic [7:0]  img_rd_data;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        result_valid;
    logic [3:0]  predicted_class;
    logic [31:0] max_score;
`ifdef SEQ_SCORE_DEBUG_EN
    logic        score_valid;
    logic [3:0]  score_class;
    logic [31:0] score_data;
`endif
    modport master (
        output start, weights_loaded, weight_rd_data, bias_rd_data, img_rd_data,
        input  weight_rd_addr, bias_rd_addr, img_rd_addr, busy, done, aborted,
               result_valid, predicted_class, max_score
`ifdef SEQ_SCORE_DEBUG_EN
        , input score_valid, score_class, score_data
`endif
    );
    modport slave (
        input  start, weights_loaded, weight_rd_data, bias_rd_data, img_rd_data,
        output weight_rd_addr, bias_rd_addr, img_rd_addr, busy, done, aborted,
               result_valid, predicted_class, max_score
`ifdef SEQ_SCORE_DEBUG_EN
        , output score_valid, score_class, score_data
`endif
    );
endinterface

// File: rtl/inference_sequencer.sv
// inference_sequencer: per-class bias+MAC scoring with argmax selection; SEQ_SCORE_DEBUG_EN adds a per-class score tap
`timescale 1ns/1ps
module inference_sequencer #(
    parameter int NUM_CLASSES = 10,
    parameter int NUM_PIXELS  = 784
) (
    input logic clk,
    input logic rst_n,
    inference_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, CMP, DONE} state_t;
    state_t             state, state_nx;
    logic [1:0]         rst_sync;
    logic [3:0]         cls;
    logic [9:0]         pix;
    logic signed [31:0] acc;
    logic signed [31:0] best;
    logic [3:0]         best_cls;
    logic signed [16:0] prod;
    logic               accept;
    logic               abort;
    logic               last_pix;
    logic               last_cls;

    assign accept   = state == IDLE && bus.start && bus.weights_loaded && rst_sync[1];
    assign abort    = state != IDLE && !bus.weights_loaded;
    assign last_pix = pix == 10'(NUM_PIXELS - 1);
    assign last_cls = cls == 4'(NUM_CLASSES - 1);
    assign prod     = $signed(bus.weight_rd_data) * $signed({1'b0, bus.img_rd_data});

    // reset release synchroniser: starts are only honoured once both stages have filled
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next state: one bias fetch, NUM_PIXELS MAC cycles, drain, compare per class; losing weights cancels the run
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? BIAS : IDLE;
            BIAS:    state_nx = MAC;
            MAC:     state_nx = last_pix ? DRAIN : MAC;
            DRAIN:   state_nx = CMP;
            CMP:     state_nx = last_cls ? DONE : BIAS;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // outputs decoded from state: read addresses are parked at 0 outside BIAS/MAC
    always_comb begin
        bus.busy           = state != IDLE;
        bus.bias_rd_addr   = state == BIAS ? cls : '0;
        bus.img_rd_addr    = state == MAC ? pix : '0;
        bus.weight_rd_addr = state == MAC ? 13'(cls * NUM_PIXELS + pix) : '0;
    end

    // datapath: counters, accumulator (read data lags its address by one cycle), running best and result registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cls                 <= '0;
            pix                 <= '0;
            acc                 <= '0;
            best                <= '0;
            best_cls            <= '0;
            bus.done            <= 1'b0;
            bus.aborted         <= 1'b0;
            bus.result_valid    <= 1'b0;
            bus.predicted_class <= '0;
            bus.max_score       <= '0;
        end else begin
            bus.done    <= state == DONE && !abort;
            bus.aborted <= abort;
            if (accept) begin
                cls              <= '0;
                pix              <= '0;
                bus.result_valid <= 1'b0;
            end
            if (state == MAC) pix <= last_pix ? '0 : pix + 10'd1;
            if (state == MAC && pix == '0) acc <= bus.bias_rd_data;
            else if (state == MAC || state == DRAIN) acc <= acc + {{15{prod[16]}}, prod};
            if (state == CMP && (cls == '0 || acc > best)) begin
                best     <= acc;
                best_cls <= cls;
            end
            if (state == CMP && !last_cls) cls <= cls + 4'd1;
            if (state == DONE && !abort) begin
                bus.result_valid    <= 1'b1;
                bus.predicted_class <= best_cls;
                bus.max_score       <= best;
            end
            if (abort) bus.result_valid <= 1'b0;
        end

`ifdef SEQ_SCORE_DEBUG_EN
    // per-class score tap, valid for the single CMP cycle of each class
    always_comb begin
        bus.score_valid = state == CMP;
        bus.score_class = cls;
        bus.score_data  = acc;
    end
`endif
endmodule
